// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bitstream framer slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bitstream_pkg;

  // Width of one stream byte.
  localparam int unsigned BYTE_W = 8;

  // FILL: collecting bytes. START: one-cycle kick to the bitstreamer.
  // WAIT: transmission in flight. GAP: guard idle time between transmissions.
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } framer_state_t;

  // Clocks the bitstreamer needs for one frame, phase delay included.
  function automatic int unsigned tx_cycles(input int unsigned datalen,
                                            input int unsigned clk_div,
                                            input int unsigned delay);
    return datalen * clk_div + delay;
  endfunction

endpackage

// File: rtl/bitstream_framer_if.sv
// Byte-stream input and bitstreamer-facing output bundle of the framer.
// Latency: n/a (wires only).
// Backpressure: byte_valid/byte_ready handshake on the byte side; bitstreamer side is push-only.
// Ports:
//   byte_data/byte_valid/byte_ready  incoming bytes, first byte ends up in the MSBs
//   phase_delay_in/repeat_n          per-frame settings, sampled with the last byte
//   abort                            cancel whatever is in progress
//   datain/phase_delay/start         drive the bitstreamer
//   busy/frame_done                  status
interface bitstream_framer_if #(
  parameter int unsigned DATALEN = 64,
  parameter int unsigned CNTLEN  = 8
);
  import bitstream_pkg::*;

  logic [BYTE_W-1:0]  byte_data;
  logic               byte_valid;
  logic               byte_ready;
  logic [CNTLEN-1:0]  phase_delay_in;
  logic [CNTLEN-1:0]  repeat_n;
  logic               abort;
  logic [DATALEN-1:0] datain;
  logic [CNTLEN-1:0]  phase_delay;
  logic               start;
  logic               busy;
  logic               frame_done;

  // Producer / controller side.
  modport master (
    output byte_data, byte_valid, phase_delay_in, repeat_n, abort,
    input  byte_ready, datain, phase_delay, start, busy, frame_done
  );

  // Framer side.
  modport slave (
    input  byte_data, byte_valid, phase_delay_in, repeat_n, abort,
    output byte_ready, datain, phase_delay, start, busy, frame_done
  );

endinterface

// File: rtl/frame_timer.sv
// Loadable down-counter timing the WAIT and GAP phases of the framer.
// Latency: after a load of N, expired is high in the N-th following cycle (N >= 1).
// Backpressure: none; load always wins over counting.
// Ports: clk, rst (sync, active low), load/value (reload), expired (last cycle of the interval).
module frame_timer #(
  parameter int unsigned TMRLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TMRLEN-1:0] value,
  output logic              expired
);

  logic [TMRLEN-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - TMRLEN'(1);
    end
  end

  // The interval loaded with N ends in the cycle the counter shows 1, so the
  // owner can reload on that same edge without losing a cycle. The counter
  // parks at 0 afterwards, which keeps this a single-cycle pulse.
  assign expired = (cnt == TMRLEN'(1));

endmodule

// File: rtl/bitstream_framer.sv
// Assembles DATALEN-bit frames from bytes and replays each to the bitstreamer repeat_n times.
// Latency: start one cycle after the last byte; each repeat takes 1 + TX + GAP cycles.
// Backpressure: byte_ready only in FILL and never in an abort cycle; bytes elsewhere are ignored.
// Ports: clk, rst (sync, active low), bus (bitstream_framer_if.slave).
module bitstream_framer
  import bitstream_pkg::*;
#(
  parameter int unsigned DATALEN  = 64,
  parameter int unsigned CNTLEN   = 8,
  parameter int unsigned CLK_DIV1 = 16,
  parameter int unsigned GAP      = 32,
  parameter int unsigned TMRLEN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  bitstream_framer_if.slave bus
);

  localparam int unsigned NBYTES = DATALEN / BYTE_W;
  localparam int unsigned CW     = $clog2(NBYTES + 1);

  // Longest interval the timer must hold: full frame plus the largest phase delay.
  localparam longint unsigned TX_MAX  = 64'(DATALEN) * 64'(CLK_DIV1) + (64'd1 << CNTLEN) - 64'd1;
  localparam longint unsigned TMR_CAP = 64'd1 << TMRLEN;

  if ((DATALEN % BYTE_W) != 0 || DATALEN < BYTE_W) begin : g_bad_datalen
    $error("bitstream_framer: DATALEN must be a non-zero multiple of 8");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("bitstream_framer: GAP must be at least 1");
  end
  if (TX_MAX >= TMR_CAP || 64'(GAP) >= TMR_CAP) begin : g_bad_tmrlen
    $error("bitstream_framer: TMRLEN too small for the transmission time");
  end

  framer_state_t      state, state_nxt;
  logic [DATALEN-1:0] shadow;
  logic [DATALEN-1:0] shadow_nxt;
  logic [CW-1:0]      byte_cnt;
  logic [CNTLEN-1:0]  rep_left;
  logic               accept;
  logic               capture;
  logic               rep_more;
  logic               tmr_load;
  logic               tmr_expired;
  logic [TMRLEN-1:0]  tmr_value;
  logic [TMRLEN-1:0]  tx_len;

  // Uses the latched delay, so every repeat of a frame has the same length.
  assign tx_len     = TMRLEN'(tx_cycles(DATALEN, CLK_DIV1, 32'(bus.phase_delay)));
  assign shadow_nxt = (shadow << BYTE_W) | DATALEN'(bus.byte_data);
  assign rep_more   = (rep_left > CNTLEN'(1));
  assign bus.busy   = (state != S_FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides everything: no handshake, no start, no timer reload.
  always_comb begin
    state_nxt      = state;
    bus.byte_ready = 1'b0;
    bus.start      = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    tmr_load       = 1'b0;
    tmr_value      = tx_len;
    if (bus.abort) begin
      state_nxt = S_FILL;
    end else begin
      case (state)
        S_FILL: begin
          bus.byte_ready = rst;
          accept         = bus.byte_valid && rst;
          if (accept && byte_cnt == CW'(NBYTES - 1)) begin
            capture   = 1'b1;
            state_nxt = S_START;
          end
        end
        S_START: begin
          bus.start = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = tx_len;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (tmr_expired) begin
            tmr_load  = 1'b1;
            tmr_value = TMRLEN'(GAP);
            state_nxt = S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_expired) begin
            state_nxt = rep_more ? S_START : S_FILL;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow          <= '0;
      byte_cnt        <= '0;
      rep_left        <= '0;
      bus.datain      <= '0;
      bus.phase_delay <= '0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (bus.abort) begin
        shadow   <= '0;
        byte_cnt <= '0;
        rep_left <= '0;
      end else begin
        if (accept) begin
          shadow   <= shadow_nxt;
          byte_cnt <= byte_cnt + CW'(1);
          if (capture) begin
            bus.datain      <= shadow_nxt;
            bus.phase_delay <= bus.phase_delay_in;
            rep_left        <= (bus.repeat_n == '0) ? CNTLEN'(1) : bus.repeat_n;
            byte_cnt        <= '0;
          end
        end
        if (state == S_GAP && tmr_expired) begin
          if (rep_more) begin
            rep_left <= rep_left - CNTLEN'(1);
          end else begin
            bus.frame_done <= 1'b1;
          end
        end
      end
    end
  end

  frame_timer #(
    .TMRLEN (TMRLEN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

endmodule

// File: tb/tb_bitstream_framer.sv
// Self-checking bench for bitstream_framer: schedule-based reference model plus directed literals.
// Latency: n/a.
// Backpressure: bytes are held until byte_ready is seen.
module tb_bitstream_framer;

  localparam int unsigned DATALEN  = 64;
  localparam int unsigned CNTLEN   = 8;
  localparam int unsigned CLK_DIV1 = 16;
  localparam int unsigned GAP      = 32;
  localparam int unsigned TMRLEN   = 16;
  localparam int          NB       = DATALEN / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bitstream_framer_if #(.DATALEN(DATALEN), .CNTLEN(CNTLEN)) bus ();

  bitstream_framer #(
    .DATALEN  (DATALEN),
    .CNTLEN   (CNTLEN),
    .CLK_DIV1 (CLK_DIV1),
    .GAP      (GAP),
    .TMRLEN   (TMRLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model: a captured frame becomes a schedule starting at cycle m_T.
  bit                 m_valid  = 0;
  bit                 m_active = 0;
  int                 m_T      = 0;
  int                 m_reps   = 0;
  int                 m_P      = 1;
  int                 m_done   = -1;
  logic [DATALEN-1:0] m_datain = '0;
  logic [CNTLEN-1:0]  m_phase  = '0;
  logic [7:0]         m_q[$];

  // Observations of the DUT, used by the directed literal checks.
  int start_cnt = 0;
  int done_cnt  = 0;
  int last_done = 0;
  int start_cycles[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: checks every cycle, then advances the model to the next edge.
  initial begin
    bit e_busy, e_start, e_done, e_ready;
    int rel;
    logic [DATALEN-1:0] d;
    forever begin
      @(negedge clk);
      rel     = cyc - m_T;
      e_busy  = m_active && (rel < m_reps * m_P);
      e_start = e_busy && ((rel % m_P) == 0) && !bus.abort;
      e_done  = (cyc == m_done);
      e_ready = !e_busy && rst && !bus.abort;
      if (m_valid) begin
        check("busy", bus.busy, e_busy);
        check("start", bus.start, e_start);
        check("frame_done", bus.frame_done, e_done);
        check("byte_ready", bus.byte_ready, e_ready);
        check("datain", bus.datain, m_datain);
        check("phase_delay", bus.phase_delay, m_phase);
        if (bus.start === 1'b1) begin
          start_cnt++;
          start_cycles.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) begin
          done_cnt++;
          last_done = cyc;
        end
      end
      if (!rst) begin
        m_valid  = 1;
        m_active = 0;
        m_done   = -1;
        m_datain = '0;
        m_phase  = '0;
        m_q.delete();
      end else if (m_valid) begin
        if (bus.abort) begin
          m_active = 0;
          if (m_done > cyc) m_done = -1;
          m_q.delete();
        end else if (!e_busy && bus.byte_valid) begin
          m_q.push_back(bus.byte_data);
          if (m_q.size() == NB) begin
            d = '0;
            for (int i = 0; i < NB; i++) d = (d << 8) | DATALEN'(m_q[i]);
            m_datain = d;
            m_phase  = bus.phase_delay_in;
            m_reps   = (bus.repeat_n == 0) ? 1 : int'(bus.repeat_n);
            m_P      = 1 + DATALEN * CLK_DIV1 + int'(bus.phase_delay_in) + GAP;
            m_T      = cyc + 1;
            m_done   = m_T + m_reps * m_P;
            m_active = 1;
            m_q.delete();
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    acc = 0;
    n   = 0;
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.byte_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL byte_accept timeout at cycle %0d: got no byte_ready, required acceptance", cyc);
    end
  endtask

  task automatic send_frame(input logic [63:0] d, input int ph, input int rn, input int maxgap);
    bus.phase_delay_in = CNTLEN'(ph);
    bus.repeat_n       = CNTLEN'(rn);
    for (int i = 0; i < NB; i++) begin
      send_byte(d[DATALEN-1-8*i -: 8]);
      if (i < NB - 1 && maxgap > 0) tick($urandom_range(0, maxgap));
    end
    // Settings after capture must not reach the latched outputs.
    bus.phase_delay_in = CNTLEN'($urandom);
    bus.repeat_n       = CNTLEN'($urandom);
  endtask

  task automatic wait_frame_done();
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL frame_done timeout at cycle %0d: got none, required one pulse", cyc);
    end
  endtask

  task automatic pulse_abort();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'($urandom);
    bus.abort      = 1'b1;
    tick(1);
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    int s_cyc, t0, sidx, d0, s0;
    logic [63:0] rd;
    bus.byte_data      = '0;
    bus.byte_valid     = 1'b0;
    bus.phase_delay_in = '0;
    bus.repeat_n       = '0;
    bus.abort          = 1'b0;

    // Reset and release.
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.byte_ready, 1);
    check("busy_after_reset", bus.busy, 0);
    check("datain_after_reset", bus.datain, 0);
    tick(1);

    // Single frame, back-to-back bytes.
    t0 = cyc;
    send_frame(64'h0102030405060708, 3, 1, 0);
    check("fill_cycles", cyc - t0, 8);
    @(negedge clk);
    check("start_after_last_byte", bus.start, 1);
    s_cyc = cyc;
    wait_frame_done();
    check("single_start_to_done", last_done - s_cyc, 1060);
    check("single_datain", bus.datain, 64'h0102030405060708);
    check("single_phase", bus.phase_delay, 3);
    tick(2);

    // Three repeats.
    sidx = start_cycles.size();
    send_frame(64'hDEADBEEF00C0FFEE, 3, 3, 0);
    wait_frame_done();
    check("repeat_start_count", start_cycles.size() - sidx, 3);
    if (start_cycles.size() >= sidx + 3) begin
      check("repeat_period_1", start_cycles[sidx+1] - start_cycles[sidx], 1060);
      check("repeat_period_2", start_cycles[sidx+2] - start_cycles[sidx+1], 1060);
      check("repeat_last_to_done", last_done - start_cycles[sidx+2], 1060);
    end
    check("repeat_datain", bus.datain, 64'hDEADBEEF00C0FFEE);
    tick(2);

    // Zero repeat behaves as one.
    s0 = start_cnt;
    send_frame(64'h8877665544332211, 0, 0, 0);
    wait_frame_done();
    check("zero_repeat_starts", start_cnt - s0, 1);

    // Gapped bytes, then byte_valid held through the transmission.
    send_frame(64'hA1B2C3D4E5F60718, 5, 1, 3);
    bus.byte_data  = 8'hAA;
    bus.byte_valid = 1'b1;
    wait_frame_done();
    bus.byte_valid = 1'b0;
    check("gapped_datain", bus.datain, 64'hA1B2C3D4E5F60718);
    pulse_abort();
    tick(1);

    // Abort after five bytes; only the following frame counts.
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
    pulse_abort();
    send_frame(64'h1112131415161718, 1, 1, 0);
    wait_frame_done();
    check("abort_fill_datain", bus.datain, 64'h1112131415161718);

    // Abort during WAIT.
    send_frame(64'h0F0E0D0C0B0A0908, 7, 2, 0);
    tick(100);
    d0 = done_cnt;
    pulse_abort();
    @(negedge clk);
    check("abort_wait_busy", bus.busy, 0);
    check("abort_wait_ready", bus.byte_ready, 1);
    tick(1300);
    check("abort_wait_no_done", done_cnt, d0);

    // Reset during GAP.
    send_frame(64'h5555AAAA5555AAAA, 0, 2, 0);
    tick(1024 + 5);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    check("gap_reset_datain", bus.datain, 0);
    check("gap_reset_phase", bus.phase_delay, 0);
    check("gap_reset_ready", bus.byte_ready, 1);
    s0 = start_cnt;
    tick(1200);
    check("gap_reset_no_start", start_cnt, s0);

    // Largest phase delay.
    send_frame(64'hCAFEF00D12345678, 255, 1, 0);
    @(negedge clk);
    s_cyc = cyc;
    wait_frame_done();
    check("max_phase_period", last_done - s_cyc, 1312);

    // Randomized frames, repeats and aborts.
    for (int it = 0; it < 12; it++) begin
      int mode, k;
      rd   = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        k = $urandom_range(1, NB - 1);
        for (int i = 0; i < k; i++) send_byte(8'($urandom));
        pulse_abort();
      end else begin
        send_frame(rd, $urandom_range(0, 40), $urandom_range(0, 2), 2);
        if (mode == 1) begin
          tick($urandom_range(0, 1500));
          pulse_abort();
        end else begin
          wait_frame_done();
        end
      end
      tick($urandom_range(0, 3));
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_framer.md
# bitstream_framer

Upstream feeder for `bitstreamer` in the antenna-modulation datapath. It assembles a `DATALEN`-bit frame from a byte stream using a valid/ready handshake, presents the frame and phase delay on the bitstreamer's `datain`/`phase_delay` inputs, and issues the one-cycle `start` pulse. It then times the transmission plus a guard gap, and repeats the frame a programmable number of times before accepting the next one.

## Interface
- `DATALEN`, 64: frame width in bits; must be a multiple of 8.
- `CNTLEN`, 8: width of `phase_delay` and `repeat_n`.
- `CLK_DIV1`, 16: bit period in clocks; must match the bitstreamer instance.
- `GAP`, 32: idle clocks between transmissions; must be ≥1.
- `TMRLEN`, 16: timer width; must hold `DATALEN*CLK_DIV1 + 2^CNTLEN - 1`.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `byte_data`  in  8  frame byte; the first byte accepted lands in the MSBs.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  framer accepts a byte this cycle.
- `phase_delay_in`  in  CNTLEN  phase delay, captured with the last byte.
- `repeat_n`  in  CNTLEN  transmissions per frame, captured with the last byte; 0 is treated as 1.
- `abort`  in  1  cancel the frame or transmission in progress.
- `datain`  out  DATALEN  frame to the bitstreamer.
- `phase_delay`  out  CNTLEN  latched delay to the bitstreamer.
- `start`  out  1  one-cycle pulse to the bitstreamer.
- `busy`  out  1  high in every state except FILL.
- `frame_done`  out  1  one-cycle pulse after the last repeat.

## Operation
- States: FILL, START, WAIT, GAP.
- **FILL**
  - `byte_ready`=1.
  - Each `byte_valid && byte_ready` shifts the byte into the shadow register, `shadow <= {shadow[DATALEN-9:0], byte_data}`, and increments `byte_cnt`.
  - On acceptance of byte `DATALEN/8`:
    - `datain <= {shadow[DATALEN-9:0], byte_data}`
    - `phase_delay <= phase_delay_in`
    - `rep_left <= max(repeat_n, 1)`
    - `byte_cnt <= 0`
    - go to START.
- **START**
  - `start`=1 for exactly this cycle.
  - Load timer with `TX = DATALEN*CLK_DIV1 + phase_delay`; go to WAIT.
- **WAIT**
  - Timer counts down, `TX` cycles in total.
  - On expiry, load timer with `GAP` and go to GAP.
- **GAP**
  - `GAP` cycles.
  - On expiry:
    - If `rep_left > 1`: decrement `rep_left` and go to START, with `datain` unchanged.
    - Otherwise: go to FILL with `frame_done`=1 for that cycle.
- `datain` and `phase_delay` change only at frame capture. They hold through every repeat and are not cleared afterwards.
- **abort** (highest priority):
  - In any state, the next state is FILL, `byte_cnt` and `rep_left` are cleared, and the shadow is discarded.
  - No `start` or `frame_done` pulse is issued.
  - A byte offered in the same cycle as `abort` is not accepted.
- `byte_valid` outside FILL is ignored; `byte_ready`=0 there.
- Timer arithmetic is unsigned, `TMRLEN` bits. Elaboration fails if `TMRLEN` is too small.

## Timing
- **Reset** (`rst`=0 at an edge):
  - State FILL.
  - `datain`=0, `phase_delay`=0, `start`=0, `busy`=0, `frame_done`=0, `byte_cnt`=0.
  - `byte_ready`=0 while `rst` is low; 1 in the first cycle after release.
  - Reset mid-transmission behaves as abort and also zeroes `datain`.
- If the last byte is accepted at edge T:
  - `start` and `busy` rise in cycle T+1.
  - WAIT occupies T+2 … T+1+TX.
  - GAP occupies T+2+TX … T+1+TX+GAP.
  - At T+2+TX+GAP comes either the next `start` or `frame_done` with `byte_ready`=1.
- Repeat period: `1 + TX + GAP` cycles.
- Back-to-back bytes are accepted at one per cycle; the minimum fill time is `DATALEN/8` cycles.

## Structure
- Package `bitstream_pkg`:
  - the state enum;
  - the `tx_cycles(DATALEN, CLK_DIV1, delay)` function;
  - the byte-width constant 8.
- Sub-module `frame_timer`: loadable `TMRLEN`-bit down-counter with `load`, `value` and an `expired` pulse, shared by WAIT and GAP.

## Test plan
All scenarios use defaults (DATALEN=64, CLK_DIV1=16, GAP=32).
- **Single frame:** 8 back-to-back bytes 0x01..0x08, phase 3, repeat 1 → `datain`=0x0102030405060708, `phase_delay`=3, `start` one cycle after the last byte, `frame_done` 1060 cycles after `start`.
- **Repeat:** `repeat_n`=3 → three `start` pulses 1060 cycles apart, `datain` constant, one `frame_done` 1060 cycles after the third pulse.
- **Zero repeat:** `repeat_n`=0 → exactly one `start`, then `frame_done`.
- **Gapped valid / backpressure:**
  - Bytes with idle cycles between them still assemble correctly.
  - `byte_valid` held during WAIT is not accepted; `byte_ready`=0 until `frame_done`.
- **Abort:**
  - Abort after 5 bytes, then 8 new bytes → only the new bytes appear in `datain`.
  - Abort during WAIT → FILL next cycle, no `frame_done`.
- **Reset:** `rst`=0 during GAP → all outputs 0, `byte_ready`=1 the cycle after release, no `start`.
